// File: rtl/serial_rx_pkg.sv
// Shared types and defaults for the framed serial receiver.
package serial_rx_pkg;

  localparam int   DEFAULT_DATA_W = 8;
  localparam logic START_LEVEL    = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

endpackage

// File: rtl/rx_hold_reg.sv
// Output holding register with valid/ready handshake and overrun detection.
module rx_hold_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              data_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              overrun
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load) begin
        // A word arriving while the previous one is still unclaimed is dropped.
        if (!data_valid || data_ready) begin
          data_out   <= word;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// Framed serial-to-parallel receiver: start, DATA_W bits LSB-first, stop.
// Define SERIAL_RX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_frame_receiver
  import serial_rx_pkg::*;
#(
  parameter int   DATA_W     = DEFAULT_DATA_W,
  parameter logic IDLE_LEVEL = ~START_LEVEL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_en,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int              CNT_W     = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic            START_BIT = ~IDLE_LEVEL;

  rx_state_t         state, state_nxt;
  logic [DATA_W-1:0] shift_reg, shift_nxt;
  logic [CNT_W-1:0]  bit_cnt, cnt_nxt;
  logic              load, load_nxt, err_nxt, word_ok;
`ifdef SERIAL_RX_PARITY_EN
  logic              par_ok, par_nxt;
`endif

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    cnt_nxt   = bit_cnt;
    load_nxt  = 1'b0;
    err_nxt   = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_nxt   = par_ok;
    word_ok   = par_ok;
`else
    word_ok   = 1'b1;
`endif
    if (bit_en) begin
      case (state)
        IDLE: begin
          if (serial_in == START_BIT) begin
            state_nxt = DATA;
            cnt_nxt   = '0;
          end
        end
        DATA: begin
          shift_nxt = {serial_in, shift_reg[DATA_W-1:1]};
          if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            cnt_nxt = bit_cnt + 1'b1;
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          par_nxt   = ~(^shift_reg ^ serial_in);
          state_nxt = STOP;
        end
`endif
        STOP: begin
          state_nxt = IDLE;
          if (serial_in == IDLE_LEVEL && word_ok) load_nxt = 1'b1;
          else                                    err_nxt  = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      load      <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_ok    <= 1'b1;
`endif
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bit_cnt   <= cnt_nxt;
      load      <= load_nxt;
      frame_err <= err_nxt;
      busy      <= (state_nxt != IDLE);
`ifdef SERIAL_RX_PARITY_EN
      par_ok    <= par_nxt;
`endif
    end
  end

  // shift_reg is stable for at least two strobes after STOP, so the
  // registered load can capture it directly one clock later.
  rx_hold_reg #(.DATA_W(DATA_W)) u_hold (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .word       (shift_reg),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed scoreboard bench for serial_frame_receiver (DATA_W=8).
module tb_serial_frame_receiver;

  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic bit_en = 1'b0;
  logic serial_in = 1'b1;
  logic data_ready = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic data_valid, frame_err, overrun, busy;

  int checks = 0;
  int passes = 0;
  int err_pulses = 0;
  int ovr_pulses = 0;
  int base;
  logic [DATA_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  serial_frame_receiver #(.DATA_W(DATA_W), .IDLE_LEVEL(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_en     (bit_en),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Transfers happen on the posedge following a cycle with valid&ready high.
  always begin
    @(negedge clk);
    #2;
    if (frame_err === 1'b1) err_pulses++;
    if (overrun === 1'b1) ovr_pulses++;
    if (reset === 1'b1 && data_valid === 1'b1 && data_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $error("FAIL sb_unexpected: observed %0h expected none", data_out);
      end else begin
        chk("sb_word", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    serial_in = b;
    bit_en = 1'b1;
    @(negedge clk);
    bit_en = 1'b0;
  endtask

  // Returns on the falling edge right after the stop bit has been sampled.
  task automatic send_frame(input logic [7:0] w, input logic stop, input logic par,
                            input int gap);
    send_bit(1'b0);
    idle(gap);
    for (int i = 0; i < 8; i++) begin
      send_bit(w[i]);
      idle(gap);
    end
`ifdef SERIAL_RX_PARITY_EN
    send_bit(par);
    idle(gap);
`else
    if (par === 1'bx) $display("note: parity unused");
`endif
    send_bit(stop);
    serial_in = 1'b1;
  endtask

  initial begin
    logic [7:0] w;
    idle(3);
    chk("rst_valid", data_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    data_ready = 1'b1;

    // single word, valid for exactly one clock
    w = 8'hA5;
    exp_q.push_back(w);
    send_frame(w, 1'b1, ^w, 2);
    chk("cap_ferr", frame_err, 0);
    chk("cap_busy", busy, 0);
    chk("cap_vld_early", data_valid, 0);
    idle(1);
    chk("cap_vld", data_valid, 1);
    chk("cap_data", data_out, 8'hA5);
    idle(1);
    chk("cap_vld_drop", data_valid, 0);

    // holding with downstream stalled
    data_ready = 1'b0;
    w = 8'h3C;
    exp_q.push_back(w);
    send_frame(w, 1'b1, ^w, 2);
    idle(1);
    for (int i = 0; i < 22; i++) begin
      chk("hold_vld", data_valid, 1);
      chk("hold_data", data_out, 8'h3C);
      idle(1);
    end
    data_ready = 1'b1;
    idle(1);
    chk("hold_release", data_valid, 0);

    // overrun
    data_ready = 1'b0;
    base = ovr_pulses;
    w = 8'h11;
    exp_q.push_back(w);
    send_frame(w, 1'b1, ^w, 2);
    idle(1);
    chk("ovr_first_vld", data_valid, 1);
    w = 8'h22;
    send_frame(w, 1'b1, ^w, 2);
    chk("ovr_early", overrun, 0);
    idle(1);
    chk("ovr_pulse", overrun, 1);
    chk("ovr_data", data_out, 8'h11);
    idle(1);
    chk("ovr_end", overrun, 0);
    chk("ovr_count", ovr_pulses - base, 1);
    data_ready = 1'b1;
    idle(1);
    chk("ovr_release", data_valid, 0);

    // framing error, then a frame with long strobe gaps
    base = err_pulses;
    w = 8'hFF;
    send_frame(w, 1'b0, ^w, 2);
    chk("ferr_pulse", frame_err, 1);
    chk("ferr_busy", busy, 0);
    idle(1);
    chk("ferr_end", frame_err, 0);
    chk("ferr_no_vld", data_valid, 0);
    chk("ferr_count", err_pulses - base, 1);
    w = 8'h5A;
    exp_q.push_back(w);
    send_frame(w, 1'b1, ^w, 12);
    idle(1);
    chk("stall_vld", data_valid, 1);
    chk("stall_data", data_out, 8'h5A);

    // back-to-back frames
    w = 8'hC3;
    exp_q.push_back(w);
    send_frame(w, 1'b1, ^w, 0);
    w = 8'h96;
    exp_q.push_back(w);
    send_frame(w, 1'b1, ^w, 0);
    idle(1);
    chk("b2b_vld", data_valid, 1);
    chk("b2b_data", data_out, 8'h96);
    idle(1);
    data_ready = 1'b0;

    // reset mid-frame
    send_bit(1'b0);
    idle(2);
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b1);
      idle(2);
    end
    chk("mid_busy", busy, 1);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_vld", data_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_ovr", overrun, 0);
    idle(2);
    reset = 1'b1;
    data_ready = 1'b1;
    w = 8'h81;
    exp_q.push_back(w);
    send_frame(w, 1'b1, ^w, 2);
    idle(1);
    chk("post_rst_vld", data_valid, 1);
    chk("post_rst_data", data_out, 8'h81);

`ifdef SERIAL_RX_PARITY_EN
    idle(2);
    w = 8'h07;
    exp_q.push_back(w);
    send_frame(w, 1'b1, 1'b1, 2);
    chk("par_ok_ferr", frame_err, 0);
    idle(1);
    chk("par_ok_data", data_out, 8'h07);
    idle(2);
    send_frame(w, 1'b1, 1'b0, 2);
    chk("par_bad_ferr", frame_err, 1);
    idle(1);
    chk("par_bad_vld", data_valid, 0);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
